// File: rtl/sram_cmd_reader_if.sv
// Bundle between the command reader, its SRAM and the controlling logic.
// The reader owns the master side; the SRAM/controller side uses slave.
interface sram_cmd_reader_if #(
   parameter int MAX_ADDR  = 10,
   parameter int DATA_SIZE = 32
);
   logic                 go;
   logic                 abort;
   logic [MAX_ADDR-1:0]  addr_out;
   logic                 re_en;
   logic [DATA_SIZE-1:0] data_in;
   logic                 cmd_valid;
   logic [1:0]           cmd_code;
   logic [MAX_ADDR:0]    start_count;
   logic                 busy;
   logic                 paused;
   logic                 done;
   logic                 err;

   modport master (
      input  go, abort, data_in,
      output addr_out, re_en,
      output cmd_valid, cmd_code, start_count,
      output busy, paused, done, err
   );

   modport slave (
      output go, abort, data_in,
      input  addr_out, re_en,
      input  cmd_valid, cmd_code, start_count,
      input  busy, paused, done, err
   );
endinterface

// File: rtl/sram_cmd_reader.sv
// Walks SRAM from address 0, decoding START/STOP/PAUSE command words
// until STOP, the last address, or abort.
module sram_cmd_reader #(
   parameter int MAX_ADDR     = 10,
   parameter int DATA_SIZE    = 32,
   parameter int LAST_ADDR    = 90,
   parameter int PAUSE_CYCLES = 4
) (
   input logic                 pulse,
   input logic                 rst,
   sram_cmd_reader_if.master   bus
);
   localparam int CW = MAX_ADDR + 1;
   localparam int HW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
   localparam logic [MAX_ADDR-1:0]  LAST      = MAX_ADDR'(LAST_ADDR);
   localparam logic [HW-1:0]        HOLD_LOAD = HW'(PAUSE_CYCLES - 1);
   localparam logic [DATA_SIZE-1:0] PAUSE_W   = {DATA_SIZE{1'b1}} >> 16;
   localparam logic [1:0] C_BAD   = 2'b00;
   localparam logic [1:0] C_START = 2'b01;
   localparam logic [1:0] C_STOP  = 2'b10;
   localparam logic [1:0] C_PAUSE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_HOLD, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [MAX_ADDR-1:0] addr_q, addr_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic                valid_q, valid_d;
   logic [1:0]          code_q, code_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                paused_q, paused_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                advance;
   logic                is_start, is_stop, is_pause;

   // Narrow words would make the PAUSE pattern alias STOP; keep them exclusive.
   assign is_start = (bus.data_in == '1);
   assign is_stop  = (bus.data_in == '0);
   assign is_pause = (DATA_SIZE > 16) && (bus.data_in == PAUSE_W);

   always_ff @(posedge pulse) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         hold_q   <= '0;
         valid_q  <= 1'b0;
         code_q   <= C_BAD;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         paused_q <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         hold_q   <= hold_d;
         valid_q  <= valid_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         paused_q <= paused_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      hold_d  = hold_q;
      valid_d = 1'b0;
      code_d  = code_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      advance = 1'b0;

      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.go) begin
                  state_d = S_FETCH;
                  addr_d  = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
               end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
               valid_d = 1'b1;
               unique case (1'b1)
                  is_start: begin
                     code_d  = C_START;
                     cnt_d   = cnt_q + CW'(1);
                     advance = 1'b1;
                  end
                  is_stop: begin
                     code_d  = C_STOP;
                     state_d = S_DONE;
                  end
                  is_pause: begin
                     code_d  = C_PAUSE;
                     hold_d  = HOLD_LOAD;
                     state_d = S_HOLD;
                  end
                  default: begin
                     code_d  = C_BAD;
                     err_d   = 1'b1;
                     advance = 1'b1;
                  end
               endcase
            end
            S_HOLD: begin
               if (hold_q == '0) advance = 1'b1;
               else hold_d = hold_q - HW'(1);
            end
            default: state_d = S_IDLE;
         endcase

         // The address saturates at LAST: the run completes instead of wrapping.
         if (advance) begin
            if (addr_q == LAST) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + MAX_ADDR'(1);
               state_d = S_FETCH;
            end
         end
      end

      busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                 (state_d == S_HOLD);
      paused_d = (state_d == S_HOLD);
      done_d   = (state_d == S_DONE);
   end

   assign bus.addr_out    = addr_q;
   assign bus.re_en       = (state_q == S_FETCH);
   assign bus.cmd_valid   = valid_q;
   assign bus.cmd_code    = code_q;
   assign bus.start_count = cnt_q;
   assign bus.busy        = busy_q;
   assign bus.paused      = paused_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_sram_cmd_reader.sv
// Randomized bench for sram_cmd_reader against a word-level run model.
// A second instance with LAST_ADDR=3 covers address saturation.
module tb_sram_cmd_reader;
   localparam int P = 4;
   localparam logic [31:0] W_START = 32'hFFFF_FFFF;
   localparam logic [31:0] W_STOP  = 32'h0000_0000;
   localparam logic [31:0] W_PAUSE = 32'h0000_FFFF;

   logic pulse = 1'b0;
   logic rst = 1'b1;
   logic go_r = 1'b0;
   logic abort_r = 1'b0;
   logic sel = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [31:0] mem [0:1023];
   logic [1:0] exp_q[$];

   always #5 pulse = ~pulse;

   sram_cmd_reader_if #(.MAX_ADDR(10), .DATA_SIZE(32)) a_if ();
   sram_cmd_reader_if #(.MAX_ADDR(10), .DATA_SIZE(32)) b_if ();

   sram_cmd_reader #(
      .MAX_ADDR(10), .DATA_SIZE(32), .LAST_ADDR(90), .PAUSE_CYCLES(P)
   ) dut (.pulse(pulse), .rst(rst), .bus(a_if));

   sram_cmd_reader #(
      .MAX_ADDR(10), .DATA_SIZE(32), .LAST_ADDR(3), .PAUSE_CYCLES(P)
   ) dut_s (.pulse(pulse), .rst(rst), .bus(b_if));

   assign a_if.go    = go_r & ~sel;
   assign b_if.go    = go_r & sel;
   assign a_if.abort = abort_r;
   assign b_if.abort = abort_r;

   always @(posedge pulse) begin
      if (a_if.re_en) a_if.data_in <= mem[a_if.addr_out];
      if (b_if.re_en) b_if.data_in <= mem[b_if.addr_out];
   end

   wire        mon_valid  = sel ? b_if.cmd_valid : a_if.cmd_valid;
   wire [1:0]  mon_code   = sel ? b_if.cmd_code : a_if.cmd_code;
   wire [10:0] mon_cnt    = sel ? b_if.start_count : a_if.start_count;
   wire [9:0]  mon_addr   = sel ? b_if.addr_out : a_if.addr_out;
   wire        mon_re     = sel ? b_if.re_en : a_if.re_en;
   wire        mon_busy   = sel ? b_if.busy : a_if.busy;
   wire        mon_paused = sel ? b_if.paused : a_if.paused;
   wire        mon_done   = sel ? b_if.done : a_if.done;
   wire        mon_err    = sel ? b_if.err : a_if.err;

   task automatic step();
      @(posedge pulse);
      #1;
   endtask

   task automatic load_std();
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000;
      mem[0] = W_START;
      mem[1] = W_START;
      mem[2] = W_PAUSE;
      mem[3] = W_START;
      mem[4] = W_START;
      mem[5] = W_STOP;
   endtask

   // Word-by-word walk of the image: 2 cycles per word plus P per PAUSE.
   task automatic model(input int last, output int ncyc, output int cnt,
                        output int fin, output int er, output int np,
                        output int nw);
      int a;
      logic [31:0] w;
      ncyc = 0; cnt = 0; er = 0; np = 0; nw = 0; a = 0;
      exp_q.delete();
      forever begin
         w = mem[a];
         nw++;
         ncyc += 2;
         if (w == W_START) begin
            exp_q.push_back(2'b01);
            cnt++;
         end else if (w == W_STOP) begin
            exp_q.push_back(2'b10);
            break;
         end else if (w == W_PAUSE) begin
            exp_q.push_back(2'b11);
            ncyc += P;
            np += P;
         end else begin
            exp_q.push_back(2'b00);
            er = 1;
         end
         if (a == last) break;
         a++;
      end
      fin = a;
   endtask

   task automatic run_check(input string nm, input int last, input bit noisy);
      int ncyc, cnt, fin, er, np, nw;
      int t, gp, gr;
      bit ok;
      logic [1:0] got[$];
      model(last, ncyc, cnt, fin, er, np, nw);
      go_r = 1'b1;
      step();
      go_r = 1'b0;
      t = 0; gp = 0; gr = 0;
      while (t < 3000) begin
         if (mon_valid) got.push_back(mon_code);
         if (mon_paused) gp++;
         if (mon_re) gr++;
         if (mon_done) break;
         if (noisy) go_r = 1'($urandom_range(0, 1));
         step();
         t++;
      end
      go_r = 1'b0;
      checks++;
      if (t !== ncyc) begin
         errors++;
         $display("FAIL %s done_cycle got %0d want %0d", nm, t, ncyc);
      end
      ok = (got.size() == exp_q.size());
      if (ok)
         for (int i = 0; i < got.size(); i++)
            if (got[i] !== exp_q[i]) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s cmd_codes got %p want %p", nm, got, exp_q);
      end
      checks++;
      if (mon_cnt !== 11'(cnt)) begin
         errors++;
         $display("FAIL %s start_count got %0d want %0d", nm, mon_cnt, cnt);
      end
      checks++;
      if (mon_addr !== 10'(fin)) begin
         errors++;
         $display("FAIL %s addr_out got %0d want %0d", nm, mon_addr, fin);
      end
      checks++;
      if (mon_err !== 1'(er)) begin
         errors++;
         $display("FAIL %s err got %0d want %0d", nm, mon_err, er);
      end
      checks++;
      if (gp !== np || gr !== nw) begin
         errors++;
         $display("FAIL %s paused/re cycles got %0d/%0d want %0d/%0d",
                  nm, gp, gr, np, nw);
      end
      checks++;
      if ({mon_busy, mon_re} !== 2'b00) begin
         errors++;
         $display("FAIL %s done busy/re got %b want 00", nm,
                  {mon_busy, mon_re});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      go_r = 1'b1;
      abort_r = 1'b1;
      step();
      step();
      checks++;
      if ({mon_valid, mon_code, mon_busy, mon_paused, mon_done, mon_err,
           mon_re} !== 8'h00) begin
         errors++;
         $display("FAIL reset flags got %b want 0", {mon_valid, mon_code,
                  mon_busy, mon_paused, mon_done, mon_err, mon_re});
      end
      checks++;
      if (mon_cnt !== 11'd0 || mon_addr !== 10'd0) begin
         errors++;
         $display("FAIL reset count/addr got %0d/%0d want 0/0",
                  mon_cnt, mon_addr);
      end
      go_r = 1'b0;
      abort_r = 1'b0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_standard();
      load_std();
      run_check("standard", 90, 1'b0);
   endtask

   task automatic test_invalid();
      load_std();
      mem[1] = 32'h0000_00A5;
      mem[3] = W_STOP;
      run_check("invalid", 90, 1'b0);
      repeat (3) step();
      checks++;
      if (mon_err !== 1'b1 || mon_done !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky err/done got %b%b want 11",
                  mon_err, mon_done);
      end
      load_std();
      run_check("err_clear", 90, 1'b0);
   endtask

   task automatic test_abort();
      int seen;
      load_std();
      go_r = 1'b1;
      step();
      go_r = 1'b0;
      repeat (7) step();
      checks++;
      if (mon_paused !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre paused got %b want 1", mon_paused);
      end
      abort_r = 1'b1;
      step();
      abort_r = 1'b0;
      checks++;
      if ({mon_busy, mon_paused, mon_done, mon_valid, mon_re} !== 5'b0 ||
          mon_cnt !== 11'd2) begin
         errors++;
         $display("FAIL abort flags/cnt got %b/%0d want 00000/2",
                  {mon_busy, mon_paused, mon_done, mon_valid, mon_re},
                  mon_cnt);
      end
      seen = 0;
      repeat (4) begin
         step();
         if (mon_re || mon_busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL abort_idle active cycles got %0d want 0", seen);
      end
   endtask

   task automatic test_go_abort();
      int seen;
      seen = 0;
      go_r = 1'b1;
      abort_r = 1'b1;
      step();
      if (mon_re || mon_busy) seen++;
      go_r = 1'b0;
      abort_r = 1'b0;
      repeat (4) begin
         step();
         if (mon_re || mon_busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL go_abort active cycles got %0d want 0", seen);
      end
   endtask

   task automatic test_last_addr();
      for (int i = 0; i < 1024; i++) mem[i] = W_START;
      sel = 1'b1;
      run_check("last_addr", 3, 1'b0);
      repeat (3) step();
      checks++;
      if (mon_addr !== 10'd3 || mon_re !== 1'b0 || mon_done !== 1'b1) begin
         errors++;
         $display("FAIL last_hold addr/re/done got %0d/%b/%b want 3/0/1",
                  mon_addr, mon_re, mon_done);
      end
      sel = 1'b0;
   endtask

   task automatic test_rst_decode();
      load_std();
      go_r = 1'b1;
      step();
      go_r = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({mon_valid, mon_code, mon_busy, mon_paused, mon_done, mon_err,
           mon_re} !== 8'h00 || mon_cnt !== 11'd0 || mon_addr !== 10'd0) begin
         errors++;
         $display("FAIL rst_decode got %b cnt %0d addr %0d want all 0",
                  {mon_valid, mon_code, mon_busy, mon_paused, mon_done,
                   mon_err, mon_re}, mon_cnt, mon_addr);
      end
      run_check("rst_restart", 90, 1'b0);
   endtask

   task automatic test_random();
      int r;
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 128; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) mem[i] = W_STOP;
            else if (r < 3) mem[i] = W_PAUSE;
            else if (r < 5) mem[i] = $urandom | 32'h0000_0100;
            else mem[i] = W_START;
         end
         sel = 1'($urandom_range(0, 1));
         run_check($sformatf("random%0d", n), sel ? 3 : 90, 1'b1);
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_standard();
      test_invalid();
      test_abort();
      test_go_abort();
      test_last_addr();
      test_rst_decode();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
